// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Shares the single CPU memory bus between the instruction-fetch port (i_*)
//   and the load/store port (d_*). Whole transactions are serialised, ties are
//   broken in favour of the port that was not served last, and a watchdog
//   forces completion of a transaction the slave never acknowledges.
//
// Ports
//   clk, rst                 clock (rising edge) and synchronous active-low reset
//   i_addr, i_valid          fetch request (word read, all byte lanes)
//   i_ready, i_rdata         fetch completion pulse and read data
//   d_addr, d_lanes,         load/store request fields
//   d_wdata, d_wr, d_valid
//   d_ready, d_rdata         load/store completion pulse and load data
//   bus_addr, bus_lanes,     request presented to the slave
//   bus_dout, bus_wr,
//   bus_valid
//   bus_din, bus_ready       slave read data and completion
//   grant_d                  1 while the load/store port owns the bus
//   timeout                  1-cycle pulse when the watchdog forces completion
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_valid,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_lanes,
    input  logic [31:0] d_wdata,
    input  logic        d_wr,
    input  logic        d_valid,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_lanes,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    output logic        bus_wr,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        grant_d,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WDOG_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = {TIMEOUT_W{1'b1}};
    localparam logic [31:0]          RDATA_TO  = 32'hFFFF_FFFF;

    state_t               state_r;
    state_t               state_nxt_s;
    state_t               state_eff_s;
    logic                 last_d_r;       // 1: data port was served last
    logic                 last_d_nxt_s;
    logic [TIMEOUT_W-1:0] wdog_r;         // completed BUSY cycles without ready
    logic [TIMEOUT_W-1:0] wdog_nxt_s;
    logic [TIMEOUT_W-1:0] wdog_inc_s;
    logic                 done_s;
    logic                 expire_s;

    // While reset is asserted the outputs behave as IDLE, so a transaction
    // interrupted by reset never produces a ready or timeout pulse.
    assign state_eff_s = rst ? state_r : IDLE;

    // wdog_inc_s counts the current BUSY cycle too; reaching all-ones means
    // this is the (2^TIMEOUT_W - 1)-th consecutive BUSY cycle.
    assign wdog_inc_s = wdog_r + WDOG_ONE;

    // Arbitration, bus steering, completion/timeout decode and next state
    always_comb begin
        state_nxt_s  = IDLE;
        last_d_nxt_s = last_d_r;
        wdog_nxt_s   = WDOG_ZERO;
        done_s       = 1'b0;
        expire_s     = 1'b0;
        bus_addr     = 32'h0000_0000;
        bus_lanes    = 4'h0;
        bus_dout     = 32'h0000_0000;
        bus_wr       = 1'b0;
        bus_valid    = 1'b0;
        i_ready      = 1'b0;
        i_rdata      = 32'h0000_0000;
        d_ready      = 1'b0;
        d_rdata      = 32'h0000_0000;

        case (state_eff_s)
            IDLE: begin
                if (i_valid && d_valid) begin
                    state_nxt_s = last_d_r ? BUSY_I : BUSY_D;
                end else if (i_valid) begin
                    state_nxt_s = BUSY_I;
                end else if (d_valid) begin
                    state_nxt_s = BUSY_D;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY_I: begin
                done_s    = i_valid & bus_ready;
                expire_s  = i_valid & ~bus_ready & (wdog_inc_s == WDOG_MAX);
                bus_addr  = i_addr;
                bus_lanes = 4'hF;
                bus_valid = i_valid & ~expire_s;
                i_ready   = done_s | expire_s;
                i_rdata   = expire_s ? RDATA_TO : bus_din;
                if (done_s || expire_s) begin
                    state_nxt_s  = IDLE;
                    last_d_nxt_s = 1'b0;
                end else if (!i_valid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY_I;
                    wdog_nxt_s  = wdog_inc_s;
                end
            end
            BUSY_D: begin
                done_s    = d_valid & bus_ready;
                expire_s  = d_valid & ~bus_ready & (wdog_inc_s == WDOG_MAX);
                bus_addr  = d_addr;
                bus_lanes = d_lanes;
                bus_dout  = d_wdata;
                bus_wr    = d_wr;
                bus_valid = d_valid & ~expire_s;
                d_ready   = done_s | expire_s;
                d_rdata   = expire_s ? RDATA_TO : bus_din;
                if (done_s || expire_s) begin
                    state_nxt_s  = IDLE;
                    last_d_nxt_s = 1'b1;
                end else if (!d_valid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY_D;
                    wdog_nxt_s  = wdog_inc_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign grant_d = (state_eff_s == BUSY_D);
    assign timeout = expire_s;

    // State, last-served port and watchdog registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
            wdog_r   <= WDOG_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            last_d_r <= last_d_nxt_s;
            wdog_r   <= wdog_nxt_s;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed scenarios for reset, single transactions, wait states, fair
//   alternation, watchdog expiry, cancellation and mid-transaction reset,
//   followed by randomized traffic checked against a transaction-level model.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TW     = 8;
    localparam int TO_CYC = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic [31:0] d_addr;
    logic [3:0]  d_lanes;
    logic [31:0] d_wdata;
    logic        d_wr;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] bus_addr;
    logic [3:0]  bus_lanes;
    logic [31:0] bus_dout;
    logic [31:0] bus_din;
    logic        bus_wr;
    logic        bus_valid;
    logic        bus_ready;
    logic        grant_d;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_valid(i_valid), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_addr(d_addr), .d_lanes(d_lanes), .d_wdata(d_wdata), .d_wr(d_wr),
        .d_valid(d_valid), .d_ready(d_ready), .d_rdata(d_rdata),
        .bus_addr(bus_addr), .bus_lanes(bus_lanes), .bus_dout(bus_dout),
        .bus_din(bus_din), .bus_wr(bus_wr), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .grant_d(grant_d), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_valid = 1'b0; i_addr = 32'h0;
        d_valid = 1'b0; d_addr = 32'h0; d_lanes = 4'h0; d_wdata = 32'h0; d_wr = 1'b0;
        bus_ready = 1'b0; bus_din = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        i_valid = 1'b1; i_addr = 32'h0000_4000;
        d_valid = 1'b1; d_addr = 32'h0000_8000; d_lanes = 4'hF;
        @(negedge clk);
        n_tests++;
        if ({bus_valid, i_ready, d_ready, timeout, grant_d} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {bus_valid, i_ready, d_ready, timeout, grant_d});
        end
        n_tests++;
        if ({bus_addr, bus_lanes, bus_dout, bus_wr} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h lanes %h dout %h wr %b expected all 0", bus_addr, bus_lanes, bus_dout, bus_wr);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || grant_d !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cycle1_idle: got valid %b grant_d %b expected 0 0", bus_valid, grant_d);
        end
        next_cycle();
        bus_ready = 1'b1; bus_din = 32'hA5A5_0001;
        @(negedge clk);
        n_tests++;
        if (grant_d !== 1'b1 || bus_valid !== 1'b1 || bus_addr !== 32'h0000_8000 ||
            d_ready !== 1'b1 || d_rdata !== 32'hA5A5_0001 || i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant_d: got grant_d %b valid %b addr %h d_ready %b d_rdata %h i_ready %b expected 1 1 00008000 1 a5a50001 0",
                     grant_d, bus_valid, bus_addr, d_ready, d_rdata, i_ready);
        end
        next_cycle();
        bus_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_between: got valid %b expected 0", bus_valid);
        end
        next_cycle();
        bus_ready = 1'b1; bus_din = 32'h5A5A_0002;
        @(negedge clk);
        n_tests++;
        if (grant_d !== 1'b0 || bus_valid !== 1'b1 || bus_addr !== 32'h0000_4000 ||
            i_ready !== 1'b1 || i_rdata !== 32'h5A5A_0002 || d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_second_grant_i: got grant_d %b valid %b addr %h i_ready %b i_rdata %h d_ready %b expected 0 1 00004000 1 5a5a0002 0",
                     grant_d, bus_valid, bus_addr, i_ready, i_rdata, d_ready);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fetch_only();
        idle_inputs();
        i_valid = 1'b1; i_addr = 32'h0000_0100; bus_ready = 1'b1; bus_din = 32'h1234_5678;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_arb_cycle: got valid %b i_ready %b expected 0 0", bus_valid, i_ready);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if ({bus_addr, bus_lanes, bus_dout, bus_wr, bus_valid} !== {32'h0000_0100, 4'hF, 32'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fetch_bus: got addr %h lanes %h dout %h wr %b valid %b expected 00000100 f 00000000 0 1",
                     bus_addr, bus_lanes, bus_dout, bus_wr, bus_valid);
        end
        n_tests++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h1234_5678 || d_ready !== 1'b0 || grant_d !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_ready: got i_ready %b i_rdata %h d_ready %b grant_d %b expected 1 12345678 0 0",
                     i_ready, i_rdata, d_ready, grant_d);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_tests++;
        if (i_ready !== 1'b0 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_pulse_width: got i_ready %b valid %b expected 0 0", i_ready, bus_valid);
        end
        next_cycle();
    endtask

    task automatic test_store_wait();
        int pulses;
        pulses = 0;
        idle_inputs();
        d_valid = 1'b1; d_addr = 32'h2000_0004; d_lanes = 4'b0011; d_wdata = 32'hCAFE_BABE; d_wr = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || grant_d !== 1'b0) begin
            n_fail++;
            $display("FAIL store_arb_cycle: got valid %b grant_d %b expected 0 0", bus_valid, grant_d);
        end
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            bus_ready = (c == 4); bus_din = 32'hDEAD_0000;
            @(negedge clk);
            n_tests++;
            if ({bus_addr, bus_lanes, bus_dout, bus_wr, bus_valid, grant_d} !==
                {32'h2000_0004, 4'b0011, 32'hCAFE_BABE, 1'b1, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL store_fields busy%0d: got addr %h lanes %b dout %h wr %b valid %b grant_d %b expected 20000004 0011 cafebabe 1 1 1",
                         c, bus_addr, bus_lanes, bus_dout, bus_wr, bus_valid, grant_d);
            end
            n_tests++;
            if (d_ready !== (c == 4) || i_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL store_ready busy%0d: got d_ready %b i_ready %b expected %b 0", c, d_ready, i_ready, (c == 4));
            end
            if (d_ready === 1'b1) pulses++;
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b0 || bus_valid !== 1'b0 || pulses != 1) begin
            n_fail++;
            $display("FAIL store_single_pulse: got d_ready %b valid %b pulses %0d expected 0 0 1", d_ready, bus_valid, pulses);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        int   n_d;
        int   n_i;
        logic exp_d;
        n_d = 0; n_i = 0;
        do_reset();
        i_valid = 1'b1; i_addr = 32'h0000_1000;
        d_valid = 1'b1; d_addr = 32'h0000_2000; d_lanes = 4'hF; d_wr = 1'b0;
        bus_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_idle txn%0d: got valid %b expected 0", k, bus_valid);
            end
            next_cycle();
            bus_din = 32'h0C00_0000 + 32'(k);
            @(negedge clk);
            exp_d = ((k % 2) == 0);
            n_tests++;
            if (grant_d !== exp_d || bus_valid !== 1'b1 || d_ready !== exp_d || i_ready !== !exp_d ||
                bus_addr !== (exp_d ? 32'h0000_2000 : 32'h0000_1000)) begin
                n_fail++;
                $display("FAIL contention_order txn%0d: got grant_d %b valid %b d_ready %b i_ready %b addr %h expected grant_d %b",
                         k, grant_d, bus_valid, d_ready, i_ready, bus_addr, exp_d);
            end
            if (bus_valid === 1'b1 && grant_d === 1'b1) n_d++;
            if (bus_valid === 1'b1 && grant_d === 1'b0) n_i++;
            next_cycle();
        end
        n_tests++;
        if (n_d != 4 || n_i != 4) begin
            n_fail++;
            $display("FAIL contention_fairness: got d %0d i %0d expected 4 4", n_d, n_i);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        idle_inputs();
        i_valid = 1'b1; i_addr = 32'h0000_3000;
        @(negedge clk);
        next_cycle();
        for (int c = 1; c <= TO_CYC; c++) begin
            @(negedge clk);
            if (c < TO_CYC) begin
                if (bus_valid !== 1'b1 || i_ready !== 1'b0 || timeout !== 1'b0) bad++;
            end else begin
                n_tests++;
                if (i_ready !== 1'b1 || i_rdata !== 32'hFFFF_FFFF || timeout !== 1'b1 || bus_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_fire: got i_ready %b i_rdata %h timeout %b valid %b expected 1 ffffffff 1 0",
                             i_ready, i_rdata, timeout, bus_valid);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL timeout_wait: got %0d bad cycles before expiry expected 0", bad);
        end
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || timeout !== 1'b0 || i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_then_idle: got valid %b timeout %b i_ready %b expected 0 0 0", bus_valid, timeout, i_ready);
        end
        next_cycle();
        bus_ready = 1'b1; bus_din = 32'h6666_0001;
        @(negedge clk);
        n_tests++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h6666_0001 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_recovery: got i_ready %b i_rdata %h timeout %b expected 1 66660001 0", i_ready, i_rdata, timeout);
        end
        next_cycle();
        // Slave answers in exactly the cycle the watchdog would fire.
        bus_ready = 1'b0;
        @(negedge clk);
        next_cycle();
        for (int c = 1; c <= TO_CYC; c++) begin
            bus_ready = (c == TO_CYC); bus_din = 32'h7777_0000;
            @(negedge clk);
            if (c == TO_CYC) begin
                n_tests++;
                if (i_ready !== 1'b1 || i_rdata !== 32'h7777_0000 || timeout !== 1'b0 || bus_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_tie: got i_ready %b i_rdata %h timeout %b valid %b expected 1 77770000 0 1",
                             i_ready, i_rdata, timeout, bus_valid);
                end
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_cancel();
        idle_inputs();
        i_valid = 1'b1; i_addr = 32'h0000_5000;
        @(negedge clk);
        next_cycle();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus_valid !== 1'b1 || i_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL cancel_busy%0d: got valid %b i_ready %b expected 1 0", c, bus_valid, i_ready);
            end
            next_cycle();
        end
        i_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || i_ready !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_drop: got valid %b i_ready %b timeout %b expected 0 0 0", bus_valid, i_ready, timeout);
        end
        next_cycle();
        i_valid = 1'b1; bus_ready = 1'b1; bus_din = 32'h5555_AAAA;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || i_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_back_to_idle: got valid %b i_ready %b expected 0 0", bus_valid, i_ready);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h5555_AAAA) begin
            n_fail++;
            $display("FAIL cancel_regrant: got i_ready %b i_rdata %h expected 1 5555aaaa", i_ready, i_rdata);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        d_valid = 1'b1; d_addr = 32'h0000_6000; d_lanes = 4'b1100; d_wdata = 32'h1111_2222; d_wr = 1'b1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (grant_d !== 1'b1 || bus_valid !== 1'b1 || d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_busy: got grant_d %b valid %b d_ready %b expected 1 1 0", grant_d, bus_valid, d_ready);
        end
        next_cycle();
        rst = 1'b0; bus_ready = 1'b1; bus_din = 32'h3333_4444;
        @(negedge clk);
        n_tests++;
        if (d_ready !== 1'b0 || timeout !== 1'b0 || bus_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_pulse: got d_ready %b timeout %b valid %b expected 0 0 0", d_ready, timeout, bus_valid);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus_valid !== 1'b0 || grant_d !== 1'b0 || d_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got valid %b grant_d %b d_ready %b expected 0 0 0", bus_valid, grant_d, d_ready);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (grant_d !== 1'b1 || d_ready !== 1'b1 || d_rdata !== 32'h3333_4444) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got grant_d %b d_ready %b d_rdata %h expected 1 1 33334444", grant_d, d_ready, d_rdata);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    // Randomized traffic against a transaction-level model: owner is 0 (none),
    // 1 (fetch) or 2 (data); cnt is the 1-based number of the current BUSY cycle.
    task automatic test_random();
        int          own;
        int          cnt;
        bit          last_d;
        bit          iv, dv, i_fin, d_fin, req, fin;
        logic [31:0] ia, da, dw, e_rd;
        logic [3:0]  dl;
        logic        dwr;
        logic [4:0]  e_ctl;
        logic [68:0] e_bus;
        do_reset();
        own = 0; cnt = 0; last_d = 1'b0;
        iv = 1'b0; dv = 1'b0; i_fin = 1'b0; d_fin = 1'b0;
        ia = 32'h0; da = 32'h0; dw = 32'h0; dl = 4'h0; dwr = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!iv) begin
                if ($urandom_range(0, 2) == 0) begin iv = 1'b1; ia = $urandom; end
            end else if (i_fin) begin
                iv = 1'($urandom_range(0, 1)); ia = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                iv = 1'b0;
            end
            if (!dv || d_fin) begin
                if (!dv) dv = ($urandom_range(0, 2) == 0);
                else     dv = 1'($urandom_range(0, 1));
                da = $urandom; dw = $urandom; dl = 4'($urandom_range(0, 15)); dwr = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) begin
                dv = 1'b0;
            end
            i_valid = iv; i_addr = ia;
            d_valid = dv; d_addr = da; d_lanes = dl; d_wdata = dw; d_wr = dwr;
            bus_ready = ($urandom_range(0, 2) != 0); bus_din = $urandom;
            @(negedge clk);
            req = 1'b0; fin = 1'b0; i_fin = 1'b0; d_fin = 1'b0;
            e_ctl = 5'b00000; e_bus = 69'd0; e_rd = 32'h0;
            if (own != 0) begin
                req   = (own == 1) ? iv : dv;
                e_bus = (own == 1) ? {ia, 4'hF, 32'h0, 1'b0} : {da, dl, dw, dwr};
                if (req && bus_ready) begin
                    fin = 1'b1; e_rd = bus_din;
                end else if (req && cnt == TO_CYC) begin
                    fin = 1'b1; e_rd = 32'hFFFF_FFFF;
                end else begin
                    fin = 1'b0;
                end
                // {bus_valid, grant_d, i_ready, d_ready, timeout}
                e_ctl = {req & ~(fin & ~bus_ready), (own == 2), fin & (own == 1), fin & (own == 2), fin & ~bus_ready};
                i_fin = fin & (own == 1);
                d_fin = fin & (own == 2);
            end
            n_tests++;
            if ({bus_valid, grant_d, i_ready, d_ready, timeout} !== e_ctl) begin
                n_fail++;
                $display("FAIL rand_ctl cyc%0d: got valid/grant_d/i_ready/d_ready/timeout %b expected %b",
                         cyc, {bus_valid, grant_d, i_ready, d_ready, timeout}, e_ctl);
            end
            n_tests++;
            if ({bus_addr, bus_lanes, bus_dout, bus_wr} !== e_bus) begin
                n_fail++;
                $display("FAIL rand_bus cyc%0d: got %h expected %h", cyc, {bus_addr, bus_lanes, bus_dout, bus_wr}, e_bus);
            end
            if (i_fin || d_fin) begin
                n_tests++;
                if ((i_fin ? i_rdata : d_rdata) !== e_rd) begin
                    n_fail++;
                    $display("FAIL rand_rdata cyc%0d: got %h expected %h", cyc, (i_fin ? i_rdata : d_rdata), e_rd);
                end
            end
            if (own == 0) begin
                if (iv && dv)  own = last_d ? 1 : 2;
                else if (iv)   own = 1;
                else if (dv)   own = 2;
                else           own = 0;
                cnt = 1;
            end else if (fin) begin
                last_d = (own == 2);
                own = 0;
            end else if (!req) begin
                own = 0;
            end else begin
                cnt++;
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_fetch_only();
        test_store_wait();
        test_contention();
        test_timeout();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
